cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Shares the single burst memory port between the instruction cache (read-only line fills) and the data cache (line fills and writebacks).
- Converts 256-bit cache-line transactions into 4-beat 64-bit bursts and reassembles read bursts into lines.
- Sits between the cache pair and the top-level memory interface.
- Sequences one line transaction at a time with round-robin fairness, so neither the fetch path feeding instruction decode nor the load/store path starves.

Parameters:
ADDR_W, 32, address width of cache and memory ports
BEAT_W, 64, memory data beat width
BEATS, 4, beats per cache line; line width = BEAT_W*BEATS

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_read  input  1  icache line-fill request, level, held until i_resp
i_addr  input  ADDR_W  icache request address
i_rdata  output  BEAT_W*BEATS  filled line to icache
i_resp  output  1  one-cycle completion pulse to icache
d_read  input  1  dcache line-fill request, level, held until d_resp
d_write  input  1  dcache writeback request, level, held until d_resp
d_addr  input  ADDR_W  dcache request address
d_wdata  input  BEAT_W*BEATS  writeback line
d_rdata  output  BEAT_W*BEATS  filled line to dcache
d_resp  output  1  one-cycle completion pulse to dcache
bmem_addr  output  ADDR_W  line-aligned burst address
bmem_read  output  1  read burst request
bmem_write  output  1  write beat valid
bmem_wdata  output  BEAT_W  write beat data
bmem_ready  input  1  memory accepts read request / write beat this cycle
bmem_rdata  input  BEAT_W  read beat data
bmem_rvalid  input  1  read beat valid

Behaviour:
- Reset: state IDLE, beat counter 0, round-robin pointer favours dcache. All outputs are 0, including i_rdata and d_rdata.
- Reset mid-burst aborts immediately. bmem_rvalid beats arriving afterwards in IDLE are discarded. No resp is issued for the aborted transaction.
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.
- IDLE arbitration, done when any request is high:
  - If only one requester is active, it is granted.
  - If both are active, the requester not granted last wins.
  - Grant is latched along with the address; the pointer updates on grant.
- Within dcache, d_write takes priority if d_read and d_write are both high (illegal, but defined).
- Address: bmem_addr = {addr[ADDR_W-1:5], 5'b0}, taken from the latched request and held constant for the whole transaction.
- Read (grant icache, or dcache with d_read):
  - RD_REQ asserts bmem_read with bmem_addr and holds it until bmem_ready; bmem_read drops the cycle after acceptance.
  - Transition to RD_DATA.
  - RD_DATA: each bmem_rvalid beat k (counter 0..BEATS-1) is written to line bits [k*BEAT_W +: BEAT_W]; beat 0 is the low bits.
  - Gaps in rvalid are allowed.
  - After beat BEATS-1, go to RESP.
- Write (dcache with d_write):
  - WR_DATA asserts bmem_write with bmem_addr and bmem_wdata = beat k of the latched d_wdata.
  - k advances only on a cycle with bmem_write && bmem_ready. Stalls with ready low hold the beat and data stable.
  - After beat BEATS-1 is accepted, go to RESP.
- RESP: the granted requester's resp is high for exactly one cycle, then IDLE.
  - The matching rdata holds the assembled line from the RESP cycle until that requester's next fill completes.
  - Writebacks do not alter d_rdata.
- Requester drops its request on the edge where resp is seen. The arbiter is in IDLE the following cycle and does not re-grant the dropped request.
- Minimum latency: read with zero-wait memory is 1 (req) + BEATS (data) + 1 (resp) cycles from grant. Write is BEATS + 1 cycles.
- bmem_read and bmem_write are never high together. Outputs change only on clock edges; all registered except combinational bmem_wdata beat select.
- A request that deasserts before grant is ignored. Request changes after grant are ignored until RESP.

Test Plan:
- icache fill alone: i_read=1, i_addr=0x1000_0024, bmem_ready=1, rdata beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x1000_0020; i_resp one cycle; i_rdata={0x44..,0x33..,0x22..,0x11..}; d_resp stays 0.
- dcache writeback with backpressure: d_write=1, d_wdata beats A,B,C,D, bmem_ready low 2 cycles on beat 1 -> bmem_wdata sequence A,B,B,B,C,D with B held through the stall; d_resp after beat D accepted; bmem_read never high.
- Simultaneous requests from reset: i_read and d_read both asserted cycle 0 and held -> dcache served first, icache served next; responses in order d_resp, i_resp; no overlap of bmem_read.
- Fairness under continuous load: both requesters re-request immediately after each resp for 6 transactions -> grants alternate D,I,D,I,D,I.
- Reset mid read after 2 beats: assert rst 1 cycle, send 2 stray rvalid beats -> no resp; i_rdata=0; next i_read completes normally with correct line.
- Gapped read data: rvalid pattern 1,0,0,1,1,0,1 -> line assembled in arrival order; resp exactly one cycle after 4th beat.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin icache/dcache line requests onto one 4x64b burst port (clk, rst, i_*/d_* line side, bmem_* beat side)
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_read,
  input  logic [ADDR_W-1:0]         i_addr,
  output logic [BEAT_W*BEATS-1:0]   i_rdata,
  output logic                      i_resp,
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [ADDR_W-1:0]         d_addr,
  input  logic [BEAT_W*BEATS-1:0]   d_wdata,
  output logic [BEAT_W*BEATS-1:0]   d_rdata,
  output logic                      d_resp,
  output logic [ADDR_W-1:0]         bmem_addr,
  output logic                      bmem_read,
  output logic                      bmem_write,
  output logic [BEAT_W-1:0]         bmem_wdata,
  input  logic                      bmem_ready,
  input  logic [BEAT_W-1:0]         bmem_rdata,
  input  logic                      bmem_rvalid
);
  localparam int LW = BEAT_W * BEATS;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic last_i, gnt_d, pick_d, wr_gnt, last;
  logic [ADDR_W-1:0] a_sel;
  logic [LW-1:0] wline, line, line_nx;
  // last_i resets high so the dcache wins the first contended grant
  always_comb begin
    pick_d = (d_read | d_write) & (~i_read | last_i);
    wr_gnt = pick_d & d_write;
    a_sel = pick_d ? d_addr : i_addr;
    last = cnt == CW'(BEATS - 1);
    line_nx = line;
    line_nx[cnt*BEAT_W +: BEAT_W] = bmem_rdata;
  end
  assign bmem_wdata = wline[cnt*BEAT_W +: BEAT_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      last_i <= 1'b1;
      gnt_d <= 1'b0;
      bmem_addr <= '0;
      bmem_read <= 1'b0;
      bmem_write <= 1'b0;
      wline <= '0;
      line <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_resp <= 1'b0;
      d_resp <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: if (i_read | d_read | d_write) begin
          gnt_d <= pick_d;
          last_i <= ~pick_d;
          bmem_addr <= a_sel & {{(ADDR_W-5){1'b1}}, 5'b0};
          wline <= d_wdata;
          cnt <= '0;
          bmem_write <= wr_gnt;
          bmem_read <= ~wr_gnt;
          state <= wr_gnt ? WR_DATA : RD_REQ;
        end
        RD_REQ: if (bmem_ready) begin
          bmem_read <= 1'b0;
          state <= RD_DATA;
        end
        RD_DATA: if (bmem_rvalid) begin
          line <= line_nx;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            state <= RESP;
            i_resp <= ~gnt_d;
            d_resp <= gnt_d;
            if (gnt_d) d_rdata <= line_nx;
            else i_rdata <= line_nx;
          end
        end
        WR_DATA: if (bmem_ready) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            bmem_write <= 1'b0;
            state <= RESP;
            d_resp <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
